button_reader: RTL and testbench
================================

# button_reader

Input-side counterpart of the LED counter path: samples the board's push buttons, debounces them, and presents clean levels plus single-cycle press, release and long-press pulses. One instance sits at the top level between the raw `user_btn` pins and user logic. It also maintains a wrapping press counter per button, so the LED block can display it.

## Interface
Parameters:
- `N_BTN`, 4: number of button channels.
- `DEBOUNCE_CYCLES`, 1_000_000: cycles a new level must hold before it is accepted (10 ms at 100 MHz). Minimum 2.
- `LONG_CYCLES`, 50_000_000: cycles held in the pressed state before `btn_long` fires (0.5 s). Must be greater than `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, 0: when 1, a raw pin value of 0 means pressed.

Ports:
- `sys_clk`, in, 1: the single clock.
- `sys_rst`, in, 1: reset, synchronous and active-high.
- `user_btn`, in, `N_BTN`: raw asynchronous button pins.
- `btn_level`, out, `N_BTN`: debounced level; 1 means pressed. Reset value 0.
- `btn_press`, out, `N_BTN`: one-cycle pulse on an accepted press. Reset value 0.
- `btn_release`, out, `N_BTN`: one-cycle pulse on an accepted release. Reset value 0.
- `btn_long`, out, `N_BTN`: one-cycle pulse, at most once per press. Reset value 0.
- `press_count`, out, `8*N_BTN`: per-channel 8-bit press count; channel i occupies bits [8i+7:8i]. Reset value 0.

## Operation
- **Per-channel input path**
  - 2-FF synchronizer, then polarity normalisation: pressed = 1.
  - Synchronizer flops reset to the released value.
- **Debounce FSM states:** UP, CHECK_DOWN, DOWN, CHECK_UP. Reset state is UP.
  - UP: if the synchronized input is 1, go to CHECK_DOWN with `deb_cnt` = 0.
  - CHECK_DOWN: if the input returns to 0, go back to UP (bounce rejected, no pulse).
    - Otherwise, when `deb_cnt` == DEBOUNCE_CYCLES-1, go to DOWN.
    - Else increment `deb_cnt`.
  - DOWN: if the input is 0, go to CHECK_UP with `deb_cnt` = 0.
  - CHECK_UP: mirror of CHECK_DOWN; it returns to DOWN on bounce and goes to UP on completion.
- **`btn_level`** is 1 in DOWN and CHECK_UP, and 0 in UP and CHECK_DOWN.
- **Pulses**
  - `btn_press` is registered and high in the first cycle of DOWN entered from CHECK_DOWN.
  - `btn_release` is high in the first cycle of UP entered from CHECK_UP.
- **Long press**
  - `long_cnt` clears on entry to DOWN from CHECK_DOWN. It counts while the FSM is in DOWN or CHECK_UP, so bounces during the hold do not restart it.
  - When `long_cnt` == LONG_CYCLES-1 and `long_done` = 0: pulse `btn_long` and set `long_done`.
  - `long_done` clears on entry to UP.
  - `long_cnt` saturates.
- **`press_count`** increments on `btn_press` and wraps 255→0.
- **Widths:** `deb_cnt` is $clog2(DEBOUNCE_CYCLES) bits; `long_cnt` is $clog2(LONG_CYCLES) bits. Comparisons are against width-extended constants.
- **Channel independence:** channels are fully independent; simultaneous events on different channels produce simultaneous pulses.

## Timing
- **Press latency:** raw level changes before edge E0 and stays stable. Then `btn_press` and `btn_level` rise at edge E0+2+DEBOUNCE_CYCLES.
  - 2 cycles are synchronizer; the FSM enters CHECK at E0+2.
- **Release latency** is identical.
- **Long-press timing:** `btn_long` is high exactly LONG_CYCLES cycles after the `btn_press` cycle, provided no completed release occurs in between.
- **Bounce rejection:** a bounce shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse.
  - A bounce of exactly DEBOUNCE_CYCLES cycles is accepted.
- **Reset mid-operation:** all outputs and counters return to reset values in the cycle after `sys_rst` is sampled high. No release pulse is emitted.
  - A button held through reset is reported as a fresh press at 2+DEBOUNCE_CYCLES cycles after reset deasserts.
- **Pulse exclusivity:** a release pulse and a long pulse cannot coincide, because long requires DOWN/CHECK_UP and release occurs on entry to UP.

## Structure
- Shared package holds the FSM state encoding (ST_UP, ST_CHECK_DOWN, ST_DOWN, ST_CHECK_UP; 2 bits) and the press-count width constant (8).
- One sub-module, `button_channel`, contains:
  - synchronizer, FSM and both counters;
  - pulse generation and the press counter.
- `button_reader` generates `N_BTN` instances and handles `ACTIVE_LOW` polarity plus output packing.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=16, N_BTN=4.
- **Clean press:** raise `user_btn[0]` before edge 10 and hold → `btn_press[0]` high only at edge 16; `btn_level[0]`=1 from edge 16; `press_count[7:0]`=1.
- **Bounce:** `user_btn[1]` high for 3 cycles then low → no `btn_press`, `btn_level[1]` stays 0.
  - Repeat with 4 cycles high, then low → press accepted, followed by a release pulse 6 cycles after the falling input.
- **Long press:** hold `user_btn[2]` for 40 cycles → single `btn_long[2]` pulse 16 cycles after `btn_press[2]`, with no second pulse.
  - A 1-cycle low glitch mid-hold does not delay it.
- **Wrap:** 256 debounced presses on channel 3 → `press_count[31:24]` reads 0; channels 0–2 are unaffected.
- **Reset while held:** assert `sys_rst` while `btn_level[0]`=1 → all outputs 0 next cycle, no `btn_release`; after deassert, `btn_press[0]` fires 6 cycles later.
- **ACTIVE_LOW=1:** drive pins low → identical press timing and values as the clean-press case.

Source files
------------

// File: rtl/button_reader_pkg.sv
// Shared definitions for the push-button reader: debounce FSM encoding and press-count width.
package button_reader_pkg;

  typedef enum logic [1:0] {
    ST_UP         = 2'd0,
    ST_CHECK_DOWN = 2'd1,
    ST_DOWN       = 2'd2,
    ST_CHECK_UP   = 2'd3
  } btn_state_e;

  localparam int unsigned PRESS_CNT_W = 8;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM, press/release/long pulses, press counter.
// The input is already normalised so that 1 means pressed.
module button_channel
  import button_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   btn_raw,
  output logic                   level,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_pulse,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LONG_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [1:0]             sync_q;
  btn_state_e             state_q, state_d;
  logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [LONG_W-1:0]      long_cnt_q;
  logic                   long_done_q;
  logic                   level_q, press_q, release_q, long_q;
  logic [PRESS_CNT_W-1:0] count_q;
  logic                   btn_in;
  logic                   press_c, release_c, held_c, long_fire_c;

  assign btn_in = sync_q[1];

  // Synchronizer resets to the released value
  always_ff @(posedge sys_clk) begin
    if (sys_rst) sync_q <= '0;
    else         sync_q <= {sync_q[0], btn_raw};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_UP;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Debounce next-state: a level must be seen DEBOUNCE_CYCLES times in CHECK before acceptance
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    unique case (state_q)
      ST_UP: begin
        if (btn_in) begin
          state_d   = ST_CHECK_DOWN;
          deb_cnt_d = '0;
        end
      end
      ST_CHECK_DOWN: begin
        if (!btn_in)                    state_d = ST_UP;
        else if (deb_cnt_q == DEB_LAST) state_d = ST_DOWN;
        else                            deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      ST_DOWN: begin
        if (!btn_in) begin
          state_d   = ST_CHECK_UP;
          deb_cnt_d = '0;
        end
      end
      ST_CHECK_UP: begin
        if (btn_in)                     state_d = ST_DOWN;
        else if (deb_cnt_q == DEB_LAST) state_d = ST_UP;
        else                            deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
      default: state_d = ST_UP;
    endcase
  end

  assign press_c   = (state_q == ST_CHECK_DOWN) && (state_d == ST_DOWN);
  assign release_c = (state_q == ST_CHECK_UP) && (state_d == ST_UP);
  assign held_c    = (state_q == ST_DOWN) || (state_q == ST_CHECK_UP);
  // Suppressed on the release edge so long and release never coincide
  assign long_fire_c = held_c && (long_cnt_q == LONG_LAST) && !long_done_q && (state_d != ST_UP);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      count_q     <= '0;
    end else begin
      level_q   <= (state_d == ST_DOWN) || (state_d == ST_CHECK_UP);
      press_q   <= press_c;
      release_q <= release_c;
      long_q    <= long_fire_c;
      if (press_c)                                 long_cnt_q <= '0;
      else if (held_c && long_cnt_q != LONG_LAST)  long_cnt_q <= long_cnt_q + LONG_W'(1);
      if (long_fire_c)             long_done_q <= 1'b1;
      else if (state_d == ST_UP)   long_done_q <= 1'b0;
      if (press_c) count_q <= count_q + PRESS_CNT_W'(1);
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: per-channel debounce with press/release/long pulses and
// wrapping press counters packed 8 bits per channel.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [N_BTN-1:0]             user_btn,
  output logic [N_BTN-1:0]             btn_level,
  output logic [N_BTN-1:0]             btn_press,
  output logic [N_BTN-1:0]             btn_release,
  output logic [N_BTN-1:0]             btn_long,
  output logic [PRESS_CNT_W*N_BTN-1:0] press_count
);

  logic [N_BTN-1:0] btn_norm;

  // Normalise so 1 means pressed; a reset synchronizer then holds the released value either way
  assign btn_norm = (ACTIVE_LOW != 0) ? ~user_btn : user_btn;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_ch (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .btn_raw       (btn_norm[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i]),
      .long_pulse    (btn_long[i]),
      .press_count   (press_count[PRESS_CNT_W*i +: PRESS_CNT_W])
    );
  end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: active-high and active-low instances share stimulus and a pulse scoreboard.
module tb_button_reader;

  localparam int unsigned N_BTN = 4;
  localparam int unsigned DEB   = 4;
  localparam int unsigned LONG  = 16;
  localparam int unsigned LAT   = 2 + DEB;
  localparam int unsigned K_PRESS   = 0;
  localparam int unsigned K_RELEASE = 1;
  localparam int unsigned K_LONG    = 2;

  typedef struct {
    int unsigned cyc;
    int unsigned kind;
    int unsigned ch;
  } ev_t;

  logic               sys_clk = 1'b0;
  logic               sys_rst;
  logic [N_BTN-1:0]   user_btn;
  logic [N_BTN-1:0]   user_btn_al;
  logic [N_BTN-1:0]   btn_level, btn_press, btn_release, btn_long;
  logic [8*N_BTN-1:0] press_count;
  logic [N_BTN-1:0]   al_level, al_press, al_release, al_long;
  logic [8*N_BTN-1:0] al_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  ev_t         sb[$];
  logic [N_BTN-1:0] exp_level;
  logic [7:0]       exp_cnt [N_BTN];

  always #5 sys_clk = ~sys_clk;
  assign user_btn_al = ~user_btn;

  button_reader #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .user_btn(user_btn),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .press_count(press_count)
  );

  button_reader #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1)
  ) dut_al (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .user_btn(user_btn_al),
    .btn_level(al_level), .btn_press(al_press), .btn_release(al_release),
    .btn_long(al_long), .press_count(al_count)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic expect_at(input int unsigned kind, input int unsigned ch, input int unsigned at);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    sb.push_back(e);
  endtask

  // Change a pin; an accepted change shows up LAT edges after the first edge that samples it
  task automatic btn_set(input int unsigned ch, input logic v, input bit accepted);
    user_btn[ch] = v;
    if (accepted) expect_at(v ? K_PRESS : K_RELEASE, ch, cyc + 1 + LAT);
  endtask

  task automatic check();
    logic [N_BTN-1:0] ep, er, el;
    logic [31:0]      ecnt;
    ep = '0;
    er = '0;
    el = '0;
    ecnt = '0;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_PRESS:   ep[sb[i].ch] = 1'b1;
          K_RELEASE: er[sb[i].ch] = 1'b1;
          default:   el[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    for (int c = 0; c < N_BTN; c++) begin
      if (ep[c]) begin
        exp_level[c] = 1'b1;
        exp_cnt[c]   = exp_cnt[c] + 8'd1;
      end
      if (er[c]) exp_level[c] = 1'b0;
      ecnt[8*c +: 8] = exp_cnt[c];
    end
    cmp("press",      32'(btn_press),   32'(ep));
    cmp("release",    32'(btn_release), 32'(er));
    cmp("long",       32'(btn_long),    32'(el));
    cmp("level",      32'(btn_level),   32'(exp_level));
    cmp("count",      32'(press_count), ecnt);
    cmp("al_press",   32'(al_press),    32'(ep));
    cmp("al_release", 32'(al_release),  32'(er));
    cmp("al_long",    32'(al_long),     32'(el));
    cmp("al_level",   32'(al_level),    32'(exp_level));
    cmp("al_count",   32'(al_count),    ecnt);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge sys_clk);
      cyc++;
      #1;
      check();
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    user_btn  = '0;
    exp_level = '0;
    for (int c = 0; c < N_BTN; c++) exp_cnt[c] = 8'd0;
    tick(3);
    sys_rst = 1'b0;
    tick(6);

    // Clean press on ch0, first sampled at edge 10; held so the long pulse follows
    btn_set(0, 1'b1, 1'b1);
    expect_at(K_LONG, 0, cyc + 1 + LAT + LONG);
    tick(7);
    cmp("clean_cyc",   32'(cyc), 32'd16);
    cmp("clean_press", 32'(btn_press[0]), 32'd1);
    cmp("clean_cnt0",  32'(press_count[7:0]), 32'd1);
    tick(20);

    // Short bounce on ch1 (3 cycles past first sample) is rejected
    btn_set(1, 1'b1, 1'b0);
    tick(4);
    btn_set(1, 1'b0, 1'b0);
    tick(10);
    cmp("bounce_level1", 32'(btn_level[1]), 32'd0);

    // Boundary bounce on ch1 (4 cycles past first sample) is accepted, then released
    btn_set(1, 1'b1, 1'b1);
    tick(5);
    btn_set(1, 1'b0, 1'b1);
    tick(10);

    // Long press on ch2 with a one-cycle glitch mid-hold
    btn_set(2, 1'b1, 1'b1);
    expect_at(K_LONG, 2, cyc + 1 + LAT + LONG);
    tick(12);
    btn_set(2, 1'b0, 1'b0);
    tick(1);
    btn_set(2, 1'b1, 1'b0);
    tick(27);
    btn_set(2, 1'b0, 1'b1);
    tick(10);

    // 256 debounced presses on ch3 wrap its counter
    repeat (256) begin
      btn_set(3, 1'b1, 1'b1);
      tick(7);
      btn_set(3, 1'b0, 1'b1);
      tick(7);
    end
    cmp("wrap_cnt3", 32'(press_count[31:24]), 32'd0);
    cmp("wrap_cnt0", 32'(press_count[7:0]),   32'd1);
    cmp("wrap_cnt1", 32'(press_count[15:8]),  32'd1);
    cmp("wrap_cnt2", 32'(press_count[23:16]), 32'd1);

    // Reset while ch0 is held: everything clears, then a fresh press
    cmp("pre_rst_level0", 32'(btn_level[0]), 32'd1);
    sys_rst = 1'b1;
    sb.delete();
    exp_level = '0;
    for (int c = 0; c < N_BTN; c++) exp_cnt[c] = 8'd0;
    tick(1);
    cmp("rst_count", 32'(press_count), 32'd0);
    sys_rst = 1'b0;
    expect_at(K_PRESS, 0, cyc + 1 + LAT);
    expect_at(K_LONG,  0, cyc + 1 + LAT + LONG);
    tick(25);
    btn_set(0, 1'b0, 1'b1);
    tick(10);

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
